diffusion_step_worker: RTL
==========================

Name: diffusion_step_worker

Overview:
- Per-engine diffusion worker, directly downstream of sync_control_dual.
- One start pulse on rdy (rdy1 or rdy2) runs one lap: walk the local frontier buffer and compute each node's push value, push = residual * weight.
- Stream non-negligible pushes to the edge-scatter stage.
- Raise finished back to the sync controller once the lap completes.

Parameters:
- DATA_WIDTH, 32, width of residual, weight, push and l_step.
- ADDR_WIDTH, 10, frontier buffer address width; max frontier size 2^ADDR_WIDTH.
- NODE_WIDTH, 20, node id width.
- FRAC_BITS, 16, fixed-point fraction bits of residual/weight/push (unsigned Q).
- EPS, 1, pushes strictly below EPS are dropped (not emitted).
- max_steps, 7, lap index at or above which the worker performs no work.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  one-cycle lap start pulse from sync_control_dual.
- l_step  in  DATA_WIDTH  current lap index, sampled on rdy.
- frontier_cnt  in  ADDR_WIDTH+1  number of valid frontier entries, sampled on rdy.
- rd_en  out  1  frontier buffer read enable.
- rd_addr  out  ADDR_WIDTH  frontier buffer read address.
- rd_node  in  NODE_WIDTH  node id; valid the cycle after rd_en.
- rd_residual  in  DATA_WIDTH  residual; valid the cycle after rd_en.
- rd_weight  in  DATA_WIDTH  precomputed alpha/degree; valid the cycle after rd_en.
- out_valid  out  1  push record valid.
- out_ready  in  1  downstream accepts the record.
- out_node  out  NODE_WIDTH  node id of the record.
- out_push  out  DATA_WIDTH  push value.
- out_step  out  DATA_WIDTH  lap index of the record.
- emitted_cnt  out  ADDR_WIDTH+1  records emitted this lap.
- finished  out  1  lap complete; level signal.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, async): state IDLE, finished=0, busy=0, rd_en=0, rd_addr=0, out_valid=0, out_node=0, out_push=0, out_step=0, emitted_cnt=0, idx=0.
- FSM states: IDLE, READ, WAIT, CALC, EMIT.
- IDLE + rdy:
  - Latch l_step into step_r and frontier_cnt into cnt_r; clear finished, emitted_cnt and idx.
  - If cnt_r==0 or l_step>=max_steps: stay IDLE; finished=1 the next cycle (1-cycle turnaround).
  - Otherwise go to READ.
- READ: rd_en=1 for exactly one cycle, rd_addr=idx; go to WAIT.
- WAIT: buffer data arrives; latch node, residual and weight; go to CALC.
- CALC: compute push.
  - prod = residual*weight, full 2*DATA_WIDTH bits, unsigned.
  - push = prod>>FRAC_BITS.
  - If any bit of push above DATA_WIDTH-1 is set, saturate to all ones.
  - Register push; go to EMIT.
- EMIT:
  - If push<EPS: no out_valid; idx++; go to READ if idx<cnt_r, else complete.
  - Otherwise hold out_valid=1 with out_node, out_push and out_step (=step_r) stable until out_ready.
  - On the handshake cycle: emitted_cnt++, idx++, out_valid drops the next cycle; go to READ or complete.
- Complete: enter IDLE and set finished=1, held until the next rdy.
- finished is a level because the sync controller ANDs both workers' finished.
- Latency and throughput: rdy at cycle 0 gives rd_en at cycle 1 and the first out_valid at cycle 4. With out_ready tied high, one entry is processed every 4 cycles.
- Last record handshaked at cycle t gives finished=1 at cycle t+1.
- rdy while busy: ignored; the lap in progress is unaffected.
- rdy in IDLE while finished=1: starts the new lap; finished drops the next cycle.
- out_ready high with out_valid low: no effect.
- frontier_cnt = 2^ADDR_WIDTH: all entries processed; the idx counter is ADDR_WIDTH+1 bits wide, so there is no wrap.
- rst asserted mid-lap: immediate return to reset values; a record in flight is lost. The sync controller must re-issue rdy.

Test Plan:
- FRAC_BITS=16, cnt=1, residual=0x00010000, weight=0x00004000, l_step=2, out_ready=1: out_valid at cycle 4 with out_push=0x00004000 and out_step=2; finished=1 at cycle 5; emitted_cnt=1.
- residual=0xFFFFFFFF, weight=0xFFFFFFFF: out_push saturates to 0xFFFFFFFF.
- cnt=3, middle entry weight=0 (push 0 < EPS): exactly 2 records emitted, emitted_cnt=2, finished after the third entry.
- out_ready held low for 5 cycles in EMIT: out_valid, out_node and out_push stay stable; exactly one handshake; no duplicate record.
- cnt=0, or l_step=7 with max_steps=7: no rd_en, finished=1 one cycle after rdy. A second rdy pulse sent while busy during a 4-entry lap is ignored: exactly 4 records emitted.
- rst low during EMIT of entry 2: all outputs return to 0 asynchronously. The next rdy restarts from idx 0.

Source files
------------

// File: rtl/diffusion_step_worker.sv
// Diffusion worker: one lap per rdy pulse, streams push = residual * weight
// for each frontier entry to the edge-scatter stage, then raises finished.
module diffusion_step_worker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned NODE_WIDTH = 20,
    parameter int unsigned FRAC_BITS  = 16,
    parameter int unsigned EPS        = 1,
    parameter int unsigned MAX_STEPS  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [DATA_WIDTH-1:0] l_step,
    input  logic [ADDR_WIDTH:0]   frontier_cnt,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [NODE_WIDTH-1:0] rd_node,
    input  logic [DATA_WIDTH-1:0] rd_residual,
    input  logic [DATA_WIDTH-1:0] rd_weight,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NODE_WIDTH-1:0] out_node,
    output logic [DATA_WIDTH-1:0] out_push,
    output logic [DATA_WIDTH-1:0] out_step,
    output logic [ADDR_WIDTH:0]   emitted_cnt,
    output logic                  finished,
    output logic                  busy
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        CALC,
        EMIT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] step_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      idx;
    logic [NODE_WIDTH-1:0] node_r;
    logic [DATA_WIDTH-1:0] res_r;
    logic [DATA_WIDTH-1:0] wt_r;
    logic [DATA_WIDTH-1:0] push_r;

    logic [PROD_W-1:0]     prod_c;
    logic [PROD_W-1:0]     scaled_c;
    logic [DATA_WIDTH-1:0] push_c;
    logic [CNT_W-1:0]      idx_next_c;
    logic                  lap_empty_c;
    logic                  push_keep_c;
    logic                  emit_drop_c;
    logic                  emit_done_c;

    // Fixed-point multiply with saturation of anything that overflows DATA_WIDTH
    always_comb begin
        prod_c      = PROD_W'(res_r) * PROD_W'(wt_r);
        scaled_c    = prod_c >> FRAC_BITS;
        push_c      = (|scaled_c[PROD_W-1:DATA_WIDTH]) ? '1 : scaled_c[DATA_WIDTH-1:0];
        push_keep_c = (push_c >= DATA_WIDTH'(EPS));
        idx_next_c  = idx + CNT_W'(1);
        lap_empty_c = (frontier_cnt == '0) || (l_step >= DATA_WIDTH'(MAX_STEPS));
        emit_drop_c = (push_r < DATA_WIDTH'(EPS));
        emit_done_c = emit_drop_c || out_ready;
    end

    // Lap sequencer: READ -> WAIT -> CALC -> EMIT per frontier entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            finished    <= 1'b0;
            busy        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            out_valid   <= 1'b0;
            out_node    <= '0;
            out_push    <= '0;
            out_step    <= '0;
            emitted_cnt <= '0;
            idx         <= '0;
            step_r      <= '0;
            cnt_r       <= '0;
            node_r      <= '0;
            res_r       <= '0;
            wt_r        <= '0;
            push_r      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy) begin
                        step_r      <= l_step;
                        cnt_r       <= frontier_cnt;
                        emitted_cnt <= '0;
                        idx         <= '0;
                        if (lap_empty_c) begin
                            // Nothing to do: report completion on the next cycle
                            finished <= 1'b1;
                        end else begin
                            finished <= 1'b0;
                            busy     <= 1'b1;
                            rd_en    <= 1'b1;
                            rd_addr  <= '0;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    rd_en <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    node_r <= rd_node;
                    res_r  <= rd_residual;
                    wt_r   <= rd_weight;
                    state  <= CALC;
                end
                CALC: begin
                    push_r <= push_c;
                    if (push_keep_c) begin
                        out_valid <= 1'b1;
                        out_node  <= node_r;
                        out_push  <= push_c;
                        out_step  <= step_r;
                    end
                    state <= EMIT;
                end
                EMIT: begin
                    if (emit_done_c) begin
                        if (!emit_drop_c) begin
                            out_valid   <= 1'b0;
                            emitted_cnt <= emitted_cnt + CNT_W'(1);
                        end
                        idx <= idx_next_c;
                        if (idx_next_c < cnt_r) begin
                            rd_en   <= 1'b1;
                            rd_addr <= idx_next_c[ADDR_WIDTH-1:0];
                            state   <= READ;
                        end else begin
                            busy     <= 1'b0;
                            finished <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
